// File: rtl/e203_ifu_bpu_ras_pkg.sv
// Shared constants and types for the IFU branch predictor with its return-address stack.
//   RFIDX_W        : register index width
//   LINK_X1/X5     : link registers recognised for call/return detection
//   bpu_state_e    : JALR-xn register-read FSM states
package e203_ifu_bpu_ras_pkg;

  localparam int RFIDX_W = 5;

  localparam logic [RFIDX_W-1:0] IDX_X0  = 5'd0;
  localparam logic [RFIDX_W-1:0] LINK_X1 = 5'd1;
  localparam logic [RFIDX_W-1:0] LINK_X5 = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEP  = 2'd1,
    ST_RDY  = 2'd2
  } bpu_state_e;

  function automatic logic is_link(input logic [RFIDX_W-1:0] idx);
    return (idx == LINK_X1) || (idx == LINK_X5);
  endfunction

endpackage

// File: rtl/e203_ifu_ras.sv
// Circular return-address stack.
//   clk, rst_n : clock, synchronous active-low reset
//   push, pop  : update requests (pop only honoured when non-empty)
//   push_val   : return address to push
//   top        : current top entry
//   empty      : no valid entries
// A push when full overwrites the oldest entry (pointer wraps, count saturates).
// Push and pop together replace the top entry in place.
module e203_ifu_ras #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_val,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr;     // index of the top entry
  logic [PW:0]     cnt;
  logic [PW-1:0]   ptr_inc;
  logic            do_pop;

  assign ptr_inc = ptr + PTR_ONE;
  assign empty   = (cnt == '0);
  assign top     = mem[ptr];
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push && do_pop) begin
      mem[ptr] <= push_val;
    end else if (push) begin
      mem[ptr_inc] <= push_val;
      ptr          <= ptr_inc;
      if (cnt != CNT_FULL) cnt <= cnt + CNT_ONE;
    end else if (do_pop) begin
      ptr <= ptr - PTR_ONE;
      cnt <= cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/e203_ifu_bpu_ras.sv
// Static IFU branch predictor with return-address stack and JALR-xn read FSM.
//   Inputs : mini-decoder info (pc, dec_*), fetch handshake/flush, hazard info
//            (oitf_empty, ir_*), regfile read data (rf2bpu_x1, rf2bpu_rs1).
//   Outputs: bpu2rf_rs1_ena/idx (regfile read request), bpu_wait (hold fetch),
//            prdt_taken and prdt_pc_add_op1/op2 (next-PC adder operands).
// Non-JALR-xn predictions are purely combinational; JALR-xn reads the shared
// regfile port once when no hazard exists and holds the result in rs1_q.
module e203_ifu_bpu_ras
  import e203_ifu_bpu_ras_pkg::*;
#(
  parameter int RAS_DEPTH = 4,
  parameter int XLEN      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [XLEN-1:0]    pc,
  input  logic               dec_i_valid,
  input  logic               dec_rv32,
  input  logic               dec_jal,
  input  logic               dec_jalr,
  input  logic               dec_bxx,
  input  logic [XLEN-1:0]    dec_bjp_imm,
  input  logic [RFIDX_W-1:0] dec_jalr_rs1idx,
  input  logic [RFIDX_W-1:0] dec_rdidx,
  input  logic               fetch_hsked,
  input  logic               flush,
  input  logic               oitf_empty,
  input  logic               ir_valid,
  input  logic               ir_rdwen,
  input  logic [RFIDX_W-1:0] ir_rdidx,
  input  logic               ir_rs1en,
  input  logic [XLEN-1:0]    rf2bpu_x1,
  input  logic [XLEN-1:0]    rf2bpu_rs1,
  output logic               bpu2rf_rs1_ena,
  output logic [RFIDX_W-1:0] bpu2rf_rs1idx,
  output logic               bpu_wait,
  output logic               prdt_taken,
  output logic [XLEN-1:0]    prdt_pc_add_op1,
  output logic [XLEN-1:0]    prdt_pc_add_op2
);

  bpu_state_e      state;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] seq_step;
  logic            ras_empty;
  logic            rd_link, rs1_link;
  logic            push_req, pop_req;
  logic            jalr_x0, jalr_ras, jalr_x1, jalr_xn;
  logic            dep_x1, dep_xn, grant, xn_trig;

  assign rd_link  = is_link(dec_rdidx);
  assign rs1_link = is_link(dec_jalr_rs1idx);
  assign seq_step = dec_rv32 ? XLEN'(4) : XLEN'(2);

  assign push_req = (dec_jal | dec_jalr) & rd_link;
  assign pop_req  = dec_jalr & rs1_link & ~ras_empty & (dec_rdidx != dec_jalr_rs1idx);

  // RAS only moves on an accepted, non-flushed instruction.
  e203_ifu_ras #(.DEPTH(RAS_DEPTH), .XLEN(XLEN)) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (dec_i_valid & fetch_hsked & ~flush & push_req),
    .pop      (dec_i_valid & fetch_hsked & ~flush & pop_req),
    .push_val (pc + seq_step),
    .top      (ras_top),
    .empty    (ras_empty)
  );

  // JALR operand source classes (mutually exclusive, priority as listed).
  assign jalr_x0  = (dec_jalr_rs1idx == IDX_X0);
  assign jalr_ras = rs1_link & ~ras_empty;
  assign jalr_x1  = (dec_jalr_rs1idx == LINK_X1) & ras_empty;
  assign jalr_xn  = ~jalr_x0 & ~jalr_ras & ~jalr_x1;

  assign dep_x1 = ~oitf_empty | (ir_valid & ir_rdwen & (ir_rdidx == LINK_X1));
  assign dep_xn = ~oitf_empty | (ir_valid & ir_rdwen & (ir_rdidx == dec_jalr_rs1idx));
  // The read port is shared with IR; yield it whenever IR is reading rs1.
  assign grant  = ~dep_xn & ~(ir_valid & ir_rs1en);
  assign xn_trig = dec_i_valid & dec_jalr & jalr_xn;

  assign bpu2rf_rs1idx  = dec_jalr_rs1idx;
  assign bpu2rf_rs1_ena = ~flush & grant &
                          (((state == ST_IDLE) & xn_trig) | (state == ST_DEP));
  assign bpu_wait = ((state == ST_IDLE) & xn_trig) | (state == ST_DEP) |
                    (dec_i_valid & dec_jalr & jalr_x1 & dep_x1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      rs1_q <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (xn_trig) begin
          state <= grant ? ST_RDY : ST_DEP;
          if (grant) rs1_q <= rf2bpu_rs1;
        end
        ST_DEP: if (grant) begin
          state <= ST_RDY;
          rs1_q <= rf2bpu_rs1;
        end
        ST_RDY: if (fetch_hsked) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    prdt_taken      = 1'b0;
    prdt_pc_add_op1 = pc;
    prdt_pc_add_op2 = seq_step;
    if (dec_jal) begin
      prdt_taken      = 1'b1;
      prdt_pc_add_op2 = dec_bjp_imm;
    end else if (dec_jalr) begin
      prdt_taken      = 1'b1;
      prdt_pc_add_op2 = dec_bjp_imm;
      if (jalr_x0)       prdt_pc_add_op1 = '0;
      else if (jalr_ras) prdt_pc_add_op1 = ras_top;
      else if (jalr_x1)  prdt_pc_add_op1 = rf2bpu_x1;
      else               prdt_pc_add_op1 = rs1_q;
    end else if (dec_bxx) begin
      // Backward branches predicted taken.
      prdt_taken      = dec_bjp_imm[XLEN-1];
      prdt_pc_add_op2 = dec_bjp_imm[XLEN-1] ? dec_bjp_imm : seq_step;
    end
  end

endmodule

// File: tb/tb_e203_ifu_bpu_ras.sv
module tb_e203_ifu_bpu_ras;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, dec_bjp_imm, rf2bpu_x1, rf2bpu_rs1;
  logic        dec_i_valid, dec_rv32, dec_jal, dec_jalr, dec_bxx;
  logic [4:0]  dec_jalr_rs1idx, dec_rdidx, ir_rdidx, bpu2rf_rs1idx;
  logic        fetch_hsked, flush, oitf_empty, ir_valid, ir_rdwen, ir_rs1en;
  logic        bpu2rf_rs1_ena, bpu_wait, prdt_taken;
  logic [31:0] prdt_pc_add_op1, prdt_pc_add_op2;

  int checks = 0;
  int failures = 0;

  e203_ifu_bpu_ras #(.RAS_DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .dec_i_valid(dec_i_valid),
    .dec_rv32(dec_rv32), .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_bxx(dec_bxx),
    .dec_bjp_imm(dec_bjp_imm), .dec_jalr_rs1idx(dec_jalr_rs1idx), .dec_rdidx(dec_rdidx),
    .fetch_hsked(fetch_hsked), .flush(flush), .oitf_empty(oitf_empty),
    .ir_valid(ir_valid), .ir_rdwen(ir_rdwen), .ir_rdidx(ir_rdidx), .ir_rs1en(ir_rs1en),
    .rf2bpu_x1(rf2bpu_x1), .rf2bpu_rs1(rf2bpu_rs1),
    .bpu2rf_rs1_ena(bpu2rf_rs1_ena), .bpu2rf_rs1idx(bpu2rf_rs1idx), .bpu_wait(bpu_wait),
    .prdt_taken(prdt_taken), .prdt_pc_add_op1(prdt_pc_add_op1), .prdt_pc_add_op2(prdt_pc_add_op2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle (inputs change on negedge) and clear all inputs.
  task automatic nxt();
    @(negedge clk);
    pc = '0; dec_i_valid = 0; dec_rv32 = 1; dec_jal = 0; dec_jalr = 0; dec_bxx = 0;
    dec_bjp_imm = '0; dec_jalr_rs1idx = '0; dec_rdidx = '0; fetch_hsked = 0; flush = 0;
    oitf_empty = 1; ir_valid = 0; ir_rdwen = 0; ir_rdidx = '0; ir_rs1en = 0;
    rf2bpu_x1 = '0; rf2bpu_rs1 = '0;
  endtask

  task automatic jal(input logic [31:0] p, input logic [31:0] imm, input logic [4:0] rd,
                     input logic hsk);
    pc = p; dec_i_valid = 1; dec_jal = 1; dec_bjp_imm = imm; dec_rdidx = rd; fetch_hsked = hsk;
  endtask

  task automatic jalr(input logic [31:0] p, input logic [4:0] rs1, input logic [4:0] rd,
                      input logic hsk);
    pc = p; dec_i_valid = 1; dec_jalr = 1; dec_bjp_imm = '0;
    dec_jalr_rs1idx = rs1; dec_rdidx = rd; fetch_hsked = hsk;
  endtask

  task automatic sense();
    #2;
  endtask

  initial begin
    rst_n = 0;
    nxt(); sense();
    chk("rst_wait", bpu_wait, 0);
    chk("rst_ena", bpu2rf_rs1_ena, 0);
    nxt();
    rst_n = 1;
    nxt(); sense();
    chk("post_rst_wait", bpu_wait, 0);
    chk("post_rst_ena", bpu2rf_rs1_ena, 0);

    // JAL with link: push 0x1004
    nxt(); jal(32'h1000, 32'h20, 5'd1, 1); sense();
    chk("jal_taken", prdt_taken, 1);
    chk("jal_op1", prdt_pc_add_op1, 32'h1000);
    chk("jal_op2", prdt_pc_add_op2, 32'h20);
    chk("jal_wait", bpu_wait, 0);

    // Branches
    nxt(); pc = 32'h2000; dec_i_valid = 1; dec_bxx = 1; dec_bjp_imm = 32'hFFFF_FFF0; sense();
    chk("bxx_back_taken", prdt_taken, 1);
    chk("bxx_back_op2", prdt_pc_add_op2, 32'hFFFF_FFF0);
    dec_bjp_imm = 32'h10; sense();
    chk("bxx_fwd_taken", prdt_taken, 0);
    chk("bxx_fwd_op2", prdt_pc_add_op2, 32'h4);
    chk("bxx_fwd_op1", prdt_pc_add_op1, 32'h2000);
    dec_bxx = 0; dec_rv32 = 0; sense();
    chk("seq16_op2", prdt_pc_add_op2, 32'h2);

    // JALR x1 returning from RAS
    nxt(); jalr(32'h3000, 5'd1, 5'd0, 1); rf2bpu_x1 = 32'hDEAD; sense();
    chk("ret_op1", prdt_pc_add_op1, 32'h1004);
    chk("ret_wait", bpu_wait, 0);
    chk("ret_taken", prdt_taken, 1);

    // RAS now empty: x1 register path waits on oitf
    for (int i = 0; i < 2; i++) begin
      nxt(); jalr(32'h3000, 5'd1, 5'd0, 0); rf2bpu_x1 = 32'hABC0; oitf_empty = 0; sense();
      chk($sformatf("x1dep_wait%0d", i), bpu_wait, 1);
    end
    nxt(); jalr(32'h3000, 5'd1, 5'd0, 1); rf2bpu_x1 = 32'hABC0; sense();
    chk("x1_wait_clear", bpu_wait, 0);
    chk("x1_op1", prdt_pc_add_op1, 32'hABC0);

    // JALR x0
    nxt(); jalr(32'h3000, 5'd0, 5'd0, 1); dec_bjp_imm = 32'h44; sense();
    chk("x0_op1", prdt_pc_add_op1, 0);
    chk("x0_op2", prdt_pc_add_op2, 32'h44);
    chk("x0_wait", bpu_wait, 0);

    // JALR x7 with IR writing x7 for 3 cycles
    for (int i = 0; i < 3; i++) begin
      nxt(); jalr(32'h4000, 5'd7, 5'd0, 0); rf2bpu_rs1 = 32'h1111;
      ir_valid = 1; ir_rdwen = 1; ir_rdidx = 5'd7; sense();
      chk($sformatf("x7_dep_wait%0d", i), bpu_wait, 1);
      chk($sformatf("x7_dep_ena%0d", i), bpu2rf_rs1_ena, 0);
    end
    nxt(); jalr(32'h4000, 5'd7, 5'd0, 0); rf2bpu_rs1 = 32'h7777; sense();
    chk("x7_grant_wait", bpu_wait, 1);
    chk("x7_grant_ena", bpu2rf_rs1_ena, 1);
    chk("x7_idx", bpu2rf_rs1idx, 5'd7);
    nxt(); jalr(32'h4000, 5'd7, 5'd0, 1); rf2bpu_rs1 = 32'h9999; sense();
    chk("x7_rdy_wait", bpu_wait, 0);
    chk("x7_rdy_ena", bpu2rf_rs1_ena, 0);
    chk("x7_rdy_op1", prdt_pc_add_op1, 32'h7777);

    // IR using shared rs1 port blocks one cycle
    nxt(); jalr(32'h4100, 5'd9, 5'd0, 0); ir_valid = 1; ir_rs1en = 1; sense();
    chk("rs1en_block_ena", bpu2rf_rs1_ena, 0);
    chk("rs1en_block_wait", bpu_wait, 1);
    nxt(); jalr(32'h4100, 5'd9, 5'd0, 0); rf2bpu_rs1 = 32'h4242; sense();
    chk("rs1en_grant_ena", bpu2rf_rs1_ena, 1);
    nxt(); jalr(32'h4100, 5'd9, 5'd0, 1); sense();
    chk("rs1en_rdy_op1", prdt_pc_add_op1, 32'h4242);

    // Flush while in DEP
    nxt(); jalr(32'h5000, 5'd7, 5'd0, 0); oitf_empty = 0; sense();
    chk("fl_dep_wait", bpu_wait, 1);
    nxt(); jalr(32'h5000, 5'd7, 5'd0, 0); flush = 1; sense();
    chk("fl_no_ena", bpu2rf_rs1_ena, 0);
    nxt(); sense();
    chk("fl_idle_wait", bpu_wait, 0);
    chk("fl_idle_ena", bpu2rf_rs1_ena, 0);

    // Five pushes into a 4-deep RAS
    for (int i = 0; i < 5; i++) begin
      nxt(); jal(32'h100 * (i + 1) - 4, 32'h8, 5'd1, 1); sense();
    end
    for (int i = 0; i < 4; i++) begin
      nxt(); jalr(32'h6000, 5'd1, 5'd0, 1); rf2bpu_x1 = 32'h5555; sense();
      chk($sformatf("pop%0d_op1", i), prdt_pc_add_op1, 32'h500 - 32'h100 * i);
      chk($sformatf("pop%0d_wait", i), bpu_wait, 0);
    end
    nxt(); jalr(32'h6000, 5'd1, 5'd0, 1); rf2bpu_x1 = 32'h5555; sense();
    chk("ras_empty_op1", prdt_pc_add_op1, 32'h5555);

    // Push and pop together replace top; count unchanged
    nxt(); jal(32'h9C, 32'h8, 5'd1, 1); sense();
    nxt(); jalr(32'h2FE, 5'd1, 5'd5, 1); dec_rv32 = 0; sense();
    chk("pp_op1", prdt_pc_add_op1, 32'hA0);
    nxt(); jalr(32'h7000, 5'd5, 5'd0, 1); sense();
    chk("pp_top_op1", prdt_pc_add_op1, 32'h300);
    nxt(); jalr(32'h7000, 5'd5, 5'd0, 0); rf2bpu_rs1 = 32'h5A5A; sense();
    chk("pp_empty_x5_ena", bpu2rf_rs1_ena, 1);
    nxt(); jalr(32'h7000, 5'd5, 5'd0, 1); sense();
    chk("pp_empty_x5_op1", prdt_pc_add_op1, 32'h5A5A);

    // Flushed handshake must not push
    nxt(); jal(32'h8000, 32'h8, 5'd1, 1); flush = 1; sense();
    nxt(); jalr(32'h8100, 5'd1, 5'd0, 1); rf2bpu_x1 = 32'h6161; sense();
    chk("flush_nopush_op1", prdt_pc_add_op1, 32'h6161);

    // Reset while in RDY
    nxt(); jal(32'h8FC, 32'h8, 5'd1, 1); sense();
    nxt(); jalr(32'h9000, 5'd9, 5'd0, 0); rf2bpu_rs1 = 32'h99; sense();
    chk("rr_grant_ena", bpu2rf_rs1_ena, 1);
    nxt(); jalr(32'h9000, 5'd9, 5'd0, 0); rst_n = 0; sense();
    chk("rr_rdy_op1", prdt_pc_add_op1, 32'h99);
    nxt(); rst_n = 1; sense();
    chk("rr_after_wait", bpu_wait, 0);
    chk("rr_after_ena", bpu2rf_rs1_ena, 0);
    nxt(); jalr(32'h9000, 5'd9, 5'd0, 0); rf2bpu_rs1 = 32'h33; sense();
    chk("rr_idle_wait", bpu_wait, 1);
    chk("rr_idle_ena", bpu2rf_rs1_ena, 1);
    nxt(); jalr(32'h9000, 5'd9, 5'd0, 1); sense();
    chk("rr_rdy2_op1", prdt_pc_add_op1, 32'h33);
    nxt(); jalr(32'h9100, 5'd1, 5'd0, 1); rf2bpu_x1 = 32'h7171; sense();
    chk("rr_ras_cleared", prdt_pc_add_op1, 32'h7171);

    nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/e203_ifu_bpu_ras.md
# e203_ifu_bpu_ras

Static branch predictor for the IFU that consumes the mini-decoder's branch/jump info bus and produces the predicted-taken flag and next-PC adder operands. Adds a small return-address stack (RAS) and a JALR-xn register-read FSM that stalls the fetch pipeline until the target operand is safe to use. Sits between the IFU mini-decoder outputs and the IFU next-PC adder and regfile BPU read port.

## Interface
Parameters:
- RAS_DEPTH, 4, number of RAS entries (power of two, ≥2)
- XLEN, 32, data and PC width

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- pc  in  XLEN  PC of instruction in decode
- dec_i_valid  in  1  decode info valid this cycle
- dec_rv32  in  1  1 = 32-bit instruction, 0 = 16-bit
- dec_jal / dec_jalr / dec_bxx  in  1 each  instruction class
- dec_bjp_imm  in  XLEN  sign-extended branch/jump offset
- dec_jalr_rs1idx  in  5  JALR rs1 index
- dec_rdidx  in  5  destination index (link detection)
- fetch_hsked  in  1  instruction accepted into IR this cycle
- flush  in  1  pipeline flush
- oitf_empty  in  1  no outstanding long-pipe writes
- ir_valid, ir_rdwen  in  1 each  IR holds an instruction that writes rd
- ir_rdidx  in  5  IR destination index
- ir_rs1en  in  1  IR stage is using the shared rs1 read port
- rf2bpu_x1  in  XLEN  live x1 value
- rf2bpu_rs1  in  XLEN  combinational regfile read data for bpu2rf_rs1idx
- bpu2rf_rs1_ena  out  1  BPU read-port request
- bpu2rf_rs1idx  out  5  = dec_jalr_rs1idx
- bpu_wait  out  1  hold fetch; next-PC outputs not yet valid
- prdt_taken  out  1  predicted taken
- prdt_pc_add_op1 / prdt_pc_add_op2  out  XLEN  next-PC adder operands

## Operation
- Link reg: idx 1 or 5. Push = (dec_jal | dec_jalr) & rd is link. Pop = dec_jalr & rs1 is link & RAS non-empty & !(rd==rs1).
- JAL: taken, op1=pc, op2=imm. Bxx: taken = imm[XLEN-1] (backward taken), op1=pc, op2=imm. Not taken/not BJP: taken=0, op1=pc, op2 = 4 if dec_rv32 else 2.
- JALR (always taken, op2=imm), op1 by rs1:
  - x0: 0, no wait.
  - link & RAS non-empty: RAS top, no wait.
  - x1 & RAS empty: rf2bpu_x1; wait while dep_x1 = !oitf_empty | (ir_valid & ir_rdwen & ir_rdidx==1).
  - other (incl. x5 & RAS empty): FSM below; dep_xn uses dec_jalr_rs1idx.
- FSM states IDLE, DEP, RDY:
  - IDLE, dec_i_valid & JALR-xn: bpu_wait=1; if !dep_xn & !(ir_valid & ir_rs1en): ena=1, capture rf2bpu_rs1 into rs1_q, → RDY; else → DEP.
  - DEP: bpu_wait=1; same grant condition → ena=1, capture, → RDY.
  - RDY: bpu_wait=0, op1=rs1_q; → IDLE on fetch_hsked or flush.
  - flush in any state → IDLE next cycle, no ena that cycle.
- RAS updates only on fetch_hsked & !flush. Push value = pc + (dec_rv32 ? 4 : 2), mod 2^XLEN.
- Full push: circular overwrite of oldest; count saturates at RAS_DEPTH; pointer wraps.
- Pop on empty impossible by definition (falls back to register path).
- Push & pop together (rs1 and rd both link, different): overwrite top, count unchanged.
- flush does not alter RAS.

## Timing
- Reset: state=IDLE, RAS count=0, pointer=0, rs1_q=0; bpu2rf_rs1_ena=0, bpu_wait=0. Other outputs are combinational from inputs.
- All non-xn predictions combinational, zero added latency.
- JALR-xn, no hazard: exactly 1 wait cycle (ena in that cycle), target valid next cycle.
- Each DEP cycle adds one wait cycle; grant one cycle after hazard clears is not allowed — grant same cycle.
- RAS pushed/popped value visible to the next decoded instruction (one-cycle update).
- bpu2rf_rs1_ena is never asserted in two consecutive cycles.

## Structure
- Shared package/defines: XLEN, RFIDX width (5), link-index constants, FSM state encodings.
- One sub-module natural: e203_ifu_ras (circular stack, push/pop/count, top output); FSM and operand mux in top.

## Test plan
- JAL pc=0x1000 imm=0x20, rd=1 -> taken=1, op1=0x1000, op2=0x20, wait=0; after hsk RAS top=0x1004.
- BEQ imm=0xFFFFFFF0 -> taken=1; imm=0x10 -> taken=0.
- JALR rs1=x1 after push of 0x1004, imm=0 -> op1=0x1004, no wait, count 1→0; repeat with empty RAS and oitf_empty=0 -> wait until oitf_empty=1.
- JALR rs1=x7, ir_rdidx=7 ir_rdwen=1 for 3 cycles -> wait 4 cycles, single ena pulse, op1=captured x7; flush while in DEP -> IDLE, no ena.
- Five link pushes 0x100,0x200,...,0x500 with RAS_DEPTH=4 -> pops return 0x500,0x400,0x300,0x200, then RAS empty.
- Reset asserted mid-RDY -> next cycle state IDLE, count 0, wait=0, ena=0.
